// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the 64-point radix-2 DIT FFT control sequencer.
package fft_ctrl_pkg;

    localparam int unsigned N      = 64;
    localparam int unsigned HALF   = 32;
    localparam int unsigned STAGES = 6;
    localparam int unsigned ADDR_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_UNLOAD  = 3'd4
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr_a;
        logic [ADDR_W-1:0] addr_b;
    } wb_req_t;

    function automatic logic [ADDR_W-1:0] bitrev6(input logic [ADDR_W-1:0] x);
        return {x[0], x[1], x[2], x[3], x[4], x[5]};
    endfunction

endpackage

// File: rtl/fft_wb_delay.sv
// Delay line aligning butterfly write-back requests with the butterfly pipeline.
module fft_wb_delay
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY = 3
) (
    input  logic    clk,
    input  logic    rst,
    input  wb_req_t d_i,
    output wb_req_t q_o
);

    generate
        if (LATENCY == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign q_o = d_i;
        end else begin : g_pipe
            wb_req_t pipe_q [LATENCY];

            // Clearing on reset drops any in-flight write-backs of an aborted frame.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < int'(LATENCY); i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= d_i;
                    for (int i = 1; i < int'(LATENCY); i++) pipe_q[i] <= pipe_q[i-1];
                end
            end

            assign q_o = pipe_q[LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/fft_control_sequencer.sv
// Frame sequencer: bit-reversed load, 6 butterfly stages with drain guard, output unload handshake.
module fft_control_sequencer
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned N_LOG2     = 6,
    parameter int unsigned BF_LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              load_we,
    output logic [N_LOG2-1:0] load_addr,
    output logic              bf_en,
    output logic [N_LOG2-1:0] bf_addr_a,
    output logic [N_LOG2-1:0] bf_addr_b,
    output logic [N_LOG2-2:0] tw_addr,
    output logic              wb_we,
    output logic [N_LOG2-1:0] wb_addr_a,
    output logic [N_LOG2-1:0] wb_addr_b,
    output logic [2:0]        stage_o,
    output logic              out_dataind,
    input  logic              out_hold,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0]        DRAIN_LAST  = (BF_LATENCY > 0) ? 3'(BF_LATENCY - 1) : 3'd0;
    localparam logic [2:0]        LAST_STAGE  = 3'(STAGES - 1);
    localparam logic [4:0]        LAST_K      = 5'(HALF - 1);
    localparam logic [N_LOG2-1:0] LAST_SAMPLE = N_LOG2'(N - 1);

    state_t            state_q, state_d;
    logic [N_LOG2-1:0] cnt_q, cnt_d;
    logic [4:0]        k_q, k_d;
    logic [2:0]        stage_q, stage_d;
    logic [2:0]        drain_q, drain_d;
    logic              seen_low_q, seen_low_d;
    logic              out_dataind_q, done_q;
    logic              accept, stage_end;

    logic [N_LOG2-1:0] span, pos, grp, addr_a, addr_b;
    logic [N_LOG2-2:0] tw;
    wb_req_t           wb_in, wb_out;

    // Butterfly operand and twiddle addresses for the current (stage, k).
    always_comb begin
        span   = N_LOG2'(1) << stage_q;
        pos    = {1'b0, k_q} & (span - N_LOG2'(1));
        grp    = {1'b0, k_q} >> stage_q;
        addr_a = (grp << (stage_q + 3'd1)) | pos;
        addr_b = addr_a + span;
        tw     = (N_LOG2-1)'(pos << (3'd5 - stage_q));
    end

    assign in_ready    = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign accept      = in_ready && in_valid;
    assign load_we     = accept;
    assign load_addr   = accept ? bitrev6(cnt_q) : '0;
    assign bf_en       = (state_q == ST_COMPUTE);
    assign bf_addr_a   = bf_en ? addr_a : '0;
    assign bf_addr_b   = bf_en ? addr_b : '0;
    assign tw_addr     = bf_en ? tw : '0;
    assign stage_o     = stage_q;
    assign busy        = (state_q != ST_IDLE);
    assign out_dataind = out_dataind_q;
    assign done        = done_q;

    assign wb_in = '{we: bf_en, addr_a: bf_addr_a, addr_b: bf_addr_b};

    fft_wb_delay #(
        .LATENCY (BF_LATENCY)
    ) u_wb_delay (
        .clk (clk),
        .rst (rst),
        .d_i (wb_in),
        .q_o (wb_out)
    );

    assign wb_we     = wb_out.we;
    assign wb_addr_a = wb_out.addr_a;
    assign wb_addr_b = wb_out.addr_b;

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        stage_d    = stage_q;
        drain_d    = drain_q;
        seen_low_d = seen_low_q;
        stage_end  = 1'b0;

        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (accept) begin
                    cnt_d   = cnt_q + N_LOG2'(1);
                    state_d = ST_LOAD;
                    if (cnt_q == LAST_SAMPLE) begin
                        state_d = ST_COMPUTE;
                        stage_d = '0;
                        k_d     = '0;
                    end
                end
            end
            ST_COMPUTE: begin
                k_d = k_q + 5'd1;
                if (k_q == LAST_K) begin
                    if (BF_LATENCY > 0) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end else begin
                        stage_end = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q + 3'd1;
                if (drain_q == DRAIN_LAST) stage_end = 1'b1;
            end
            ST_UNLOAD: begin
                if (seen_low_q && out_hold) begin
                    state_d    = ST_IDLE;
                    seen_low_d = 1'b0;
                end else if (!out_hold) begin
                    seen_low_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A stage is complete once its last butterfly has been written back.
        if (stage_end) begin
            k_d = '0;
            if (stage_q == LAST_STAGE) begin
                state_d    = ST_UNLOAD;
                stage_d    = '0;
                seen_low_d = 1'b0;
            end else begin
                state_d = ST_COMPUTE;
                stage_d = stage_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            k_q           <= '0;
            stage_q       <= '0;
            drain_q       <= '0;
            seen_low_q    <= 1'b0;
            out_dataind_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            k_q           <= k_d;
            stage_q       <= stage_d;
            drain_q       <= drain_d;
            seen_low_q    <= seen_low_d;
            out_dataind_q <= (state_d == ST_UNLOAD) && (state_q != ST_UNLOAD);
            done_q        <= (state_q == ST_UNLOAD) && (state_d == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_fft_control_sequencer.sv
// Randomized bench for fft_control_sequencer against a frame-level timing/address model.
module tb_fft_control_sequencer;

    localparam int TB_LAT         = 3;
    localparam int P              = 32 + TB_LAT;
    localparam int COMPUTE_CYCLES = 6 * P;

    logic       clk = 1'b0;
    logic       rst, in_valid, out_hold;
    logic       in_ready, load_we, bf_en, wb_we, out_dataind, busy, done;
    logic [5:0] load_addr, bf_addr_a, bf_addr_b, wb_addr_a, wb_addr_b;
    logic [4:0] tw_addr;
    logic [2:0] stage_o;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 idle, 1 load, 2 compute (m_t = cycle index), 3 unload.
    int m_mode = 0, m_cnt = 0, m_t = 0;
    bit m_first = 0, m_seen = 0, m_done = 0;
    bit en_chk = 0, post_rst_chk = 0;
    int cc = 0, done_cnt = 0, frames = 0;

    always #5 clk = ~clk;

    fft_control_sequencer #(.N_LOG2(6), .BF_LATENCY(TB_LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .load_we(load_we), .load_addr(load_addr), .bf_en(bf_en),
        .bf_addr_a(bf_addr_a), .bf_addr_b(bf_addr_b), .tw_addr(tw_addr),
        .wb_we(wb_we), .wb_addr_a(wb_addr_a), .wb_addr_b(wb_addr_b),
        .stage_o(stage_o), .out_dataind(out_dataind), .out_hold(out_hold),
        .busy(busy), .done(done)
    );

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int brev(input int x);
        int r;
        r = 0;
        for (int i = 0; i < 6; i++)
            if (((x / (2 ** i)) % 2) == 1) r = r + 2 ** (5 - i);
        return r;
    endfunction

    // Butterfly issued at compute cycle t, from stage/pair arithmetic.
    function automatic void bf_model(input int t, output int en, output int a, output int b,
                                     output int tw, output int st);
        int r, span, pos, grp;
        st = t / P;
        r  = t % P;
        en = (r < 32) ? 1 : 0;
        a = 0; b = 0; tw = 0;
        if (en == 1) begin
            span = 2 ** st;
            pos  = r % span;
            grp  = r / span;
            a    = grp * 2 * span + pos;
            b    = a + span;
            tw   = pos * (32 / span);
        end
    endfunction

    // Per-cycle compare against the model, then model advance.
    initial forever begin
        int e_rdy, e_we, e_bf, e_a, e_b, e_tw, e_st, e_wb, e_wa, e_wbb, d0, d1;
        @(negedge clk);
        if (en_chk) begin
            if (post_rst_chk) begin
                chk("post_rst_wb_we", int'(wb_we), 0);
                chk("post_rst_busy", int'(busy), 0);
                chk("post_rst_in_ready", int'(in_ready), 1);
                post_rst_chk = 0;
            end
            e_rdy = (m_mode <= 1) ? 1 : 0;
            e_we  = (e_rdy == 1 && in_valid) ? 1 : 0;
            e_bf = 0; e_a = 0; e_b = 0; e_tw = 0; e_st = 0; e_wb = 0; e_wa = 0; e_wbb = 0;
            if (m_mode == 2) begin
                bf_model(m_t, e_bf, e_a, e_b, e_tw, e_st);
                if (m_t >= TB_LAT) bf_model(m_t - TB_LAT, e_wb, e_wa, e_wbb, d0, d1);
            end
            chk("in_ready", int'(in_ready), e_rdy);
            chk("load_we", int'(load_we), e_we);
            if (e_we == 1) chk("load_addr", int'(load_addr), brev(m_cnt));
            chk("busy", int'(busy), (m_mode != 0) ? 1 : 0);
            chk("bf_en", int'(bf_en), e_bf);
            if (e_bf == 1) begin
                chk("bf_addr_a", int'(bf_addr_a), e_a);
                chk("bf_addr_b", int'(bf_addr_b), e_b);
                chk("tw_addr", int'(tw_addr), e_tw);
            end
            chk("stage_o", int'(stage_o), e_st);
            chk("wb_we", int'(wb_we), e_wb);
            if (e_wb == 1) begin
                chk("wb_addr_a", int'(wb_addr_a), e_wa);
                chk("wb_addr_b", int'(wb_addr_b), e_wbb);
            end
            chk("out_dataind", int'(out_dataind), (m_mode == 3 && m_first) ? 1 : 0);
            chk("done", int'(done), m_done ? 1 : 0);

            // Hand-computed pins from the worked examples.
            if (load_we && m_cnt == 1)  chk("pin_load_1", int'(load_addr), 32);
            if (load_we && m_cnt == 6)  chk("pin_load_6", int'(load_addr), 24);
            if (load_we && m_cnt == 11) chk("pin_load_11", int'(load_addr), 52);
            if (load_we && m_cnt == 63) chk("pin_load_63", int'(load_addr), 63);
            if (m_mode == 2 && m_t == 5) begin
                chk("pin_s0k5_a", int'(bf_addr_a), 10);
                chk("pin_s0k5_b", int'(bf_addr_b), 11);
                chk("pin_s0k5_tw", int'(tw_addr), 0);
            end
            if (m_mode == 2 && m_t == 2 * P + 5) begin
                chk("pin_s2k5_a", int'(bf_addr_a), 9);
                chk("pin_s2k5_b", int'(bf_addr_b), 13);
                chk("pin_s2k5_tw", int'(tw_addr), 8);
            end
            if (m_mode == 2 && m_t == 5 * P + 31) begin
                chk("pin_s5k31_a", int'(bf_addr_a), 31);
                chk("pin_s5k31_b", int'(bf_addr_b), 63);
                chk("pin_s5k31_tw", int'(tw_addr), 31);
            end
            if (out_dataind) chk("compute_cycles", cc, 210);
            if (in_ready) cc = 0;
            else cc++;
            if (done) done_cnt++;
            if (rst && m_mode == 2) post_rst_chk = 1;

            if (rst) begin
                m_mode = 0; m_cnt = 0; m_t = 0; m_first = 0; m_seen = 0; m_done = 0;
            end else begin
                m_done = 0;
                case (m_mode)
                    0, 1: if (in_valid) begin
                        m_cnt++;
                        m_mode = 1;
                        if (m_cnt == 64) begin m_mode = 2; m_cnt = 0; m_t = 0; end
                    end
                    2: begin
                        m_t++;
                        if (m_t == COMPUTE_CYCLES) begin m_mode = 3; m_first = 1; m_seen = 0; end
                    end
                    default: begin
                        m_first = 0;
                        if (m_seen && out_hold) begin m_mode = 0; m_done = 1; end
                        else if (!out_hold) m_seen = 1;
                    end
                endcase
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input bit rnd, input bit hold_hi, input bit do_rst);
        int  guard, stall;
        bit  stalled;
        stall = 0; stalled = 0; guard = 0;
        while (m_mode <= 1 && guard < 1000) begin
            if (!rnd && m_cnt == 11 && !stalled) begin stall = 5; stalled = 1; end
            if (stall > 0) begin in_valid = 1'b0; stall--; end
            else in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            step();
            guard++;
        end
        chk("compute_entry_in_ready", int'(in_ready), 0);

        guard = 0;
        while (m_mode == 2 && guard < 2000) begin
            in_valid = 1'($urandom_range(0, 1));
            if (do_rst && m_t == 3 * P + 17) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                in_valid = 1'b0;
                return;
            end
            step();
            guard++;
        end
        chk("unload_entry_pulse", int'(out_dataind), 1);

        if (hold_hi) begin
            repeat (80) begin in_valid = 1'($urandom_range(0, 1)); step(); end
            chk("hold_high_busy", int'(busy), 1);
            chk("hold_high_in_ready", int'(in_ready), 0);
            out_hold = 1'b0;
            repeat ($urandom_range(1, 6)) step();
            out_hold = 1'b1;
        end else begin
            step();
            out_hold = 1'b0;
            repeat (64) begin in_valid = 1'($urandom_range(0, 1)); step(); end
            out_hold = 1'b1;
        end
        in_valid = 1'b0;
        guard = 0;
        while (m_mode != 0 && guard < 50) begin step(); guard++; end
        chk("unload_return_ready", int'(in_ready), 1);
        step();
        frames++;
        chk("done_pulses", done_cnt, frames);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_hold = 1'b1;
        step();
        en_chk = 1;
        step();
        step();
        rst = 1'b0;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_bf_en", int'(bf_en), 0);
        chk("reset_wb_we", int'(wb_we), 0);
        chk("reset_stage", int'(stage_o), 0);
        chk("reset_dataind", int'(out_dataind), 0);

        run_frame(1'b0, 1'b0, 1'b0);
        run_frame(1'b1, 1'b1, 1'b0);
        run_frame(1'b1, 1'b0, 1'b1);
        run_frame(1'b1, 1'b0, 1'b0);
        run_frame(1'b1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
